// File: rtl/serial_reduce_pkg.sv
// Shared types and helpers for the bit-serial NAND reduction unit.
package serial_reduce_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first deserializer: each enabled beat lands the incoming bit at position idx_i.
// word_o already includes the bit being written this cycle, so the frame is complete on its last beat.
module serial_shift_in
    import serial_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [CNT_W(WIDTH)-1:0] idx_i,
    input  logic                    d_i,
    output logic [WIDTH-1:0]        word_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        word_o        = sr_q;
        word_o[idx_i] = d_i;
    end

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = word_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_reduce_nand.sv
// Bit-serial NAND reducer: collects WIDTH bits LSB-first, then holds the NAND flag
// and the deserialized word on a valid/ready output until downstream takes them.
module serial_reduce_nand
    import serial_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic             ABORT,
    output logic             O,
    output logic [WIDTH-1:0] O_WORD,
    output logic             O_VALID,
    input  logic             O_READY
);

    localparam int            CW   = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             o_q, o_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] frame_w;
    logic             in_fire, out_fire, sr_clr;

    // Handshake outputs come straight from the state register: no input-to-output path.
    assign I_READY  = (state_q == COLLECT);
    assign O_VALID  = (state_q == HOLD);
    assign in_fire  = I_VALID && I_READY;
    assign out_fire = O_VALID && O_READY;
    assign O        = o_q;
    assign O_WORD   = word_q;

    serial_shift_in #(.WIDTH(WIDTH)) u_shift (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .en_i   (in_fire && !ABORT),
        .clr_i  (sr_clr),
        .idx_i  (cnt_q),
        .d_i    (I),
        .word_o (frame_w)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        o_d     = o_q;
        word_d  = word_q;
        sr_clr  = 1'b0;
        if (ABORT) begin
            state_d = COLLECT;
            cnt_d   = '0;
            acc_d   = 1'b1;
            sr_clr  = 1'b1;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_fire) begin
                        if (cnt_q == LAST) begin
                            o_d     = ~(acc_q & I);
                            word_d  = frame_w;
                            cnt_d   = '0;
                            acc_d   = 1'b1;
                            sr_clr  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            acc_d = acc_q & I;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) state_d = COLLECT;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            acc_q   <= 1'b1;
            o_q     <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: doc/serial_reduce_nand.md
# serial_reduce_nand

Bit-serial NAND reduction unit. Consumes a WIDTH-bit frame one bit per valid/ready beat, LSB first, and presents both the NAND of all frame bits and the deserialized frame word on a valid/ready output. It is the sequential counterpart of the parallel LUT-chain NAND reducers. It sits on a serial link ahead of logic that needs a per-frame reduction flag.

## Interface
Parameters:
- WIDTH, 8, bits per frame; legal range 2..64.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  reset; asynchronous, active-low.
- I  input  1  serial data bit.
- I_VALID  input  1  I carries a bit this cycle.
- I_READY  output  1  block accepts a bit this cycle.
- ABORT  input  1  synchronous frame flush; takes priority over everything else.
- O  output  1  NAND of the completed frame.
- O_WORD  output  WIDTH  completed frame; bit k is the k-th accepted bit.
- O_VALID  output  1  O and O_WORD hold a completed frame.
- O_READY  input  1  downstream takes the result.

## Operation
- Beat: a bit transfers when I_VALID and I_READY are both high. A result transfers when O_VALID and O_READY are both high.
- FSM has two states.
  - COLLECT:
    - I_READY=1, O_VALID=0.
    - Each accepted beat writes I into shift register position cnt, updates acc &= I, and increments cnt.
    - On the beat where cnt==WIDTH-1:
      - O <= ~(acc & I).
      - O_WORD <= completed word, including the current bit.
      - cnt <= 0, acc <= 1.
      - Next state HOLD.
  - HOLD:
    - I_READY=0, O_VALID=1.
    - O and O_WORD are stable.
    - On an output beat, go to COLLECT.
- ABORT high at a clock edge, in any state:
  - cnt <= 0, acc <= 1, shift register cleared.
  - O_VALID drops.
  - Next state COLLECT.
  - Any bit or result handshake in that same cycle is discarded.
- I_VALID gaps are allowed at any point in a frame. No timeout.
- In HOLD, I_VALID and I are ignored and the upstream must hold its bit.
- Reset values:
  - State COLLECT, cnt=0, acc=1.
  - O=0, O_WORD=0, O_VALID=0, I_READY=1.
- Reset asserted mid-frame or mid-HOLD drops the partial frame or pending result immediately.
- Width rules:
  - cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.
  - acc is 1 bit.
  - O_WORD is exactly WIDTH bits with no padding.

## Timing
- I_READY and O_VALID are decoded from registered state only, with no combinational path from any input.
- O_VALID rises in the cycle after the final bit beat.
- Result latency from the first bit is at least WIDTH cycles.
- Peak throughput is one frame per WIDTH+1 cycles: WIDTH bit beats plus one HOLD cycle with O_READY held high.
- An output beat in cycle t makes I_READY high in cycle t+1. There is no same-cycle turnaround.
- ABORT takes effect at the edge where it is sampled, and I_READY=1 in the following cycle.

## Structure
- Shared package serial_reduce_pkg holds:
  - the state enum (COLLECT, HOLD),
  - localparam function CNT_W(WIDTH) = $clog2(WIDTH).
- One sub-module, serial_shift_in:
  - WIDTH-bit LSB-first shift register with load-enable and synchronous clear.
  - Its parallel output feeds the O_WORD register.
- The top level contains the FSM, cnt, acc, and the output registers.

## Test plan
- Reset then 0xFF: after reset, WIDTH=8, feed 0xFF LSB-first with I_VALID held high.
  - O_VALID rises on cycle 9 with O=0, O_WORD=0xFF.
  - I_READY=0 while in HOLD.
- Frame 0xFE: feed 0xFE with O_READY=1.
  - Result O=1, O_WORD=0xFE.
  - A second frame 0x00 then yields O=1, O_WORD=0x00, one cycle after the result handshake plus 8 beats.
- Backpressure: after a result, hold O_READY=0 for 3 cycles while I_VALID=1 and I=0.
  - No bit is consumed and O and O_WORD are unchanged.
  - After O_READY=1, the next frame collects normally.
- Bubbles: feed 0x81 with I_VALID toggling 1,0,1,0,...
  - Result arrives only after 8 accepted beats: O=1, O_WORD=0x81.
- ABORT mid-frame: after 5 bits of 0x00, pulse ABORT, then feed 0xFF.
  - Result O=0, O_WORD=0xFF.
  - ABORT pulsed in HOLD drops O_VALID next cycle.
- Async reset mid-frame: assert RESETN=0 between clock edges after 3 bits.
  - O_VALID=0, O=0, O_WORD=0 and I_READY=1 immediately.
  - After release, a full 0xAA frame gives O=1, O_WORD=0xAA.
